// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the multi-cycle CPU control sequencer:
// state encoding and memory address-select values.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  // Memory address mux select: program counter or data address.
  localparam logic ADDR_PC   = 1'b0;
  localparam logic ADDR_DATA = 1'b1;

endpackage

// File: rtl/cpu_seq_timeout.sv
// Memory wait counter for the sequencer. Counts cycles spent waiting on
// mem_ready and raises tc once TIMEOUT_CYCLES-1 wait cycles have elapsed.
// The counter saturates at terminal count so it never wraps back to zero.
module cpu_seq_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic tc
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] count_reg;

  // Wait-cycle counter: cleared on state entry, advanced while memory stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && !tc) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign tc = (count_reg == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC | MEM, sharing
// one memory port between instruction fetch and data access.
// Optional feature: define CPU_SEQ_MEM_TIMEOUT_EN to fault the sequencer
// when mem_ready stays low for TIMEOUT_CYCLES cycles in FETCH or MEM.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             dec_ld,
  input  logic             dec_st,
  input  logic             dec_br,
  input  logic             dec_wr,
  input  logic             dec_halt,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             reg_wr,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("cpu_sequencer: TIMEOUT_CYCLES must be at least 2");
  end

  state_t           state_reg, state_next;
  logic             run_sample, run_prev;
  logic             run_rise;
  logic             retire;
  logic             timeout_hit;
  logic [CNT_W-1:0] count_reg;

  // run is sampled once, then a second flop detects the sampled rising edge;
  // this gives the two-cycle resume latency and ignores a held-high level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_sample <= 1'b0;
      run_prev   <= 1'b0;
    end else begin
      run_sample <= run;
      run_prev   <= run_sample;
    end
  end

  assign run_rise = run_sample & ~run_prev;

`ifdef CPU_SEQ_MEM_TIMEOUT_EN
  cpu_seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (state_next != state_reg),
    .inc   (((state_reg == ST_FETCH) || (state_reg == ST_MEM)) && !mem_ready),
    .tc    (timeout_hit)
  );
  assign fault = (state_reg == ST_FAULT);
`else
  assign timeout_hit = 1'b0;
  assign fault       = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and strobe decode; mem_req depends on state only.
  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = ADDR_PC;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    reg_wr     = 1'b0;
    retire     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (run_rise) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req  = 1'b1;
        addr_sel = ADDR_PC;
        if (mem_ready) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          state_next = ST_DECODE;
        end else if (timeout_hit) begin
          state_next = ST_FAULT;
        end
      end
      ST_DECODE: begin
        if (dec_halt)              state_next = ST_HALT;
        else if (dec_st || dec_ld) state_next = ST_MEM;
        else                       state_next = ST_EXEC;
      end
      ST_EXEC: begin
        reg_wr     = dec_wr;
        pc_load    = dec_br;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = ADDR_DATA;
        mem_we   = dec_st;
        if (mem_ready) begin
          reg_wr     = dec_ld & ~dec_st;
          retire     = 1'b1;
          state_next = ST_FETCH;
        end else if (timeout_hit) begin
          state_next = ST_FAULT;
        end
      end
      ST_HALT: begin
        if (run_rise) state_next = ST_FETCH;
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (retire) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign state       = state_reg;
  assign halted      = (state_reg == ST_HALT);
  assign instr_count = count_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus a random
// instruction stream, checked per cycle against an instruction-level model.
module tb_cpu_sequencer;

  localparam int CNT_W = 4;
  localparam int TMO   = 4;

  logic clk = 1'b0;
  logic reset, run, dec_ld, dec_st, dec_br, dec_wr, dec_halt, mem_ready;
  logic mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, reg_wr, halted, fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  int tests = 0;
  int fails = 0;
  int model_count = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(
    .CNT_W(CNT_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .run(run),
    .dec_ld(dec_ld), .dec_st(dec_st), .dec_br(dec_br), .dec_wr(dec_wr),
    .dec_halt(dec_halt), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .reg_wr(reg_wr),
    .state(state), .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected output vector: strobes, halted/fault derived from the phase, state code.
  function automatic logic [31:0] pack(input logic [2:0] st, input bit req, we, asel,
                                       irl, pci, pcl, rw);
    return {20'd0, req, we, asel, irl, pci, pcl, rw, (st == 3'd5), (st == 3'd6), st};
  endfunction

  function automatic logic [31:0] obs();
    return {20'd0, mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, reg_wr,
            halted, fault, state};
  endfunction

  // Check outputs mid-cycle, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [31:0] exp);
    @(negedge clk);
    check(tag, obs(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_dec();
    {dec_ld, dec_st, dec_br, dec_wr, dec_halt} = 5'($urandom);
  endtask

  // Run from IDLE: raise run; FETCH is reached two edges later.
  task automatic start_run();
    run = 1'b1;
    cyc("run_lat0", pack(3'd0, 0, 0, 0, 0, 0, 0, 0));
    run = 1'b0;
    cyc("run_lat1", pack(3'd0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // One instruction starting in FETCH; fw/mw are wait cycles on the memory port.
  task automatic do_instr(input bit ld, st, br, wr, hlt, input int fw, input int mw);
    for (int i = 0; i < fw; i++) begin
      mem_ready = 1'b0; scramble_dec();
      cyc("fetch_wait", pack(3'd1, 1, 0, 0, 0, 0, 0, 0));
    end
    mem_ready = 1'b1; scramble_dec();
    cyc("fetch_done", pack(3'd1, 1, 0, 0, 1, 1, 0, 0));
    dec_ld = ld; dec_st = st; dec_br = br; dec_wr = wr; dec_halt = hlt;
    mem_ready = 1'($urandom);
    cyc("decode", pack(3'd2, 0, 0, 0, 0, 0, 0, 0));
    if (hlt) return;
    if (ld || st) begin
      for (int i = 0; i < mw; i++) begin
        mem_ready = 1'b0;
        cyc("mem_wait", pack(3'd4, 1, st, 1, 0, 0, 0, 0));
      end
      mem_ready = 1'b1;
      cyc("mem_done", pack(3'd4, 1, st, 1, 0, 0, 0, ld & ~st));
    end else begin
      mem_ready = 1'($urandom);
      cyc("exec", pack(3'd3, 0, 0, 0, 0, 0, br, wr));
    end
    model_count = (model_count + 1) % (1 << CNT_W);
    check("retire_count", 32'(instr_count), 32'(model_count));
  endtask

  // Sit in HALT (optionally with run held high), then resume with a fresh edge.
  task automatic halt_and_resume(input int dwell);
    for (int i = 0; i < dwell; i++) begin
      mem_ready = 1'($urandom); scramble_dec();
      cyc("halt_hold", pack(3'd5, 0, 0, 0, 0, 0, 0, 0));
    end
    check("halt_count", 32'(instr_count), 32'(model_count));
    if (run) begin
      run = 1'b0;
      cyc("halt_run_low", pack(3'd5, 0, 0, 0, 0, 0, 0, 0));
    end
    run = 1'b1;
    cyc("resume_lat0", pack(3'd5, 0, 0, 0, 0, 0, 0, 0));
    run = 1'b0;
    cyc("resume_lat1", pack(3'd5, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    bit ld, st, br, wr, hlt, hold;
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0;
    {dec_ld, dec_st, dec_br, dec_wr, dec_halt} = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", obs(), pack(3'd0, 0, 0, 0, 0, 0, 0, 0));
    check("reset_count", 32'(instr_count), 32'd0);
    reset = 1'b0;
    cyc("idle_no_run", pack(3'd0, 0, 0, 0, 0, 0, 0, 0));
    start_run();

    // Directed: ALU write, load with 3 waits, load+store collision, branch.
    do_instr(0, 0, 0, 1, 0, 0, 0);
    do_instr(1, 0, 0, 0, 0, 2, 3);
    do_instr(1, 1, 0, 1, 0, 0, 1);
    do_instr(0, 1, 1, 0, 0, 3, 0);
    do_instr(0, 0, 1, 0, 0, 1, 0);

    // Directed halt with run held high across it.
    run = 1'b1;
    do_instr(1, 1, 1, 1, 1, 0, 0);
    halt_and_resume(4);

    // Random instruction stream; wait counts stay below the timeout.
    for (int n = 0; n < 150; n++) begin
      {ld, st, br, wr} = 4'($urandom);
      hlt  = ($urandom_range(0, 9) == 0);
      hold = 1'($urandom);
      if (hlt && hold) run = 1'b1;
      do_instr(ld, st, br, wr, hlt, $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1));
      if (hlt) halt_and_resume($urandom_range(1, 4));
    end

    // Asynchronous reset while MEM holds the port.
    mem_ready = 1'b1;
    cyc("pre_rst_fetch", pack(3'd1, 1, 0, 0, 1, 1, 0, 0));
    dec_ld = 1'b1; dec_st = 1'b0; dec_br = 1'b0; dec_wr = 1'b0; dec_halt = 1'b0;
    cyc("pre_rst_decode", pack(3'd2, 0, 0, 0, 0, 0, 0, 0));
    mem_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_mem", obs(), pack(3'd4, 1, 0, 1, 0, 0, 0, 0));
    #2 reset = 1'b1;
    #1;
    check("rst_async_out", obs(), pack(3'd0, 0, 0, 0, 0, 0, 0, 0));
    check("rst_async_count", 32'(instr_count), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_count = 0;
    start_run();
    do_instr(0, 0, 0, 1, 0, 0, 0);

`ifdef CPU_SEQ_MEM_TIMEOUT_EN
    // Memory never answers a fetch: fault after TMO wait cycles, sticky.
    for (int i = 0; i < TMO; i++) begin
      mem_ready = 1'b0;
      cyc("tmo_fetch", pack(3'd1, 1, 0, 0, 0, 0, 0, 0));
    end
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'($urandom); run = 1'(i);
      cyc("tmo_fault", pack(3'd6, 0, 0, 0, 0, 0, 0, 0));
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; run = 1'b0;
    check("tmo_reset", obs(), pack(3'd0, 0, 0, 0, 0, 0, 0, 0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the CPU core. It steps each instruction through fetch, decode, execute and memory-access phases, and drives the IR load, PC increment/load and register write-enable strobes. It also owns the single memory port, multiplexing it between instruction fetch and data access. It sits between the instruction decoder, the PC/IR registers and the memory interface.

## Interface
Parameters:
- `CNT_W`, 16: width of the retired-instruction counter.
- `TIMEOUT_CYCLES`, 16: maximum number of wait cycles on `mem_ready` before a fault. Used only when the timeout feature is compiled in. Must be ≥2.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `run` in 1: start/resume request; acts on its rising edge only.
- `dec_ld` in 1: decoded instruction is a load.
- `dec_st` in 1: decoded instruction is a store.
- `dec_br` in 1: decoded branch is taken.
- `dec_wr` in 1: decoded ALU instruction writes the register file.
- `dec_halt` in 1: decoded instruction is a halt.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write enable.
- `addr_sel` out 1: memory address select; 0 = PC, 1 = data address.
- `ir_load` out 1: load the IR.
- `pc_inc` out 1: increment the PC.
- `pc_load` out 1: load the PC with the branch target.
- `reg_wr` out 1: register file write enable.
- `state` out 3: current state encoding.
- `halted` out 1: high in HALT state.
- `fault` out 1: sticky memory-timeout fault.
- `instr_count` out CNT_W: count of retired instructions.

## Operation
- States:
  - IDLE = 0
  - FETCH = 1
  - DECODE = 2
  - EXEC = 3
  - MEM = 4
  - HALT = 5
  - FAULT = 6
- Reset values:
  - State is IDLE.
  - All strobes are 0.
  - `fault` = 0, `instr_count` = 0, `halted` = 0.
  - The registered `run` sample is 0.
- IDLE: on a `run` rising edge → FETCH.
- FETCH:
  - Drives `mem_req` = 1, `addr_sel` = 0.
  - When `mem_ready` = 1: `ir_load` = 1 and `pc_inc` = 1 in that same cycle (Mealy), then → DECODE.
  - Otherwise it stays in FETCH.
- DECODE: one cycle, no strobes.
  - Priority: `dec_halt` → HALT; else `dec_st` or `dec_ld` → MEM; else → EXEC.
- EXEC: one cycle.
  - `reg_wr` = `dec_wr`, `pc_load` = `dec_br`.
  - `instr_count` increments; → FETCH.
- MEM:
  - Drives `mem_req` = 1, `addr_sel` = 1, `mem_we` = `dec_st`.
  - When `mem_ready` = 1: `reg_wr` = `dec_ld & ~dec_st`, `instr_count` increments, → FETCH.
  - If both `dec_ld` and `dec_st` are set, the store wins.
- HALT:
  - `halted` = 1, all strobes 0.
  - The halt instruction does not increment `instr_count`.
  - On a `run` rising edge → FETCH. A level-high `run` held across the halt does not resume.
- FAULT: all strobes 0, `fault` = 1. Only `reset` exits this state.
- The decoder inputs are held stable by the IR from DECODE through the end of EXEC/MEM; the sequencer does not register them.
- `instr_count` wraps modulo 2^CNT_W.
- `reset` asserted mid-transaction forces IDLE immediately and drops `mem_req` asynchronously.

## Timing
- Minimum instruction time with zero-wait memory:
  - ALU/branch: 3 cycles (FETCH, DECODE, EXEC).
  - Load/store: 3 cycles (FETCH, DECODE, MEM).
- Each cycle of `mem_ready` = 0 adds one cycle.
- Resume latency: `mem_req` rises 2 cycles after the `run` rising edge (1 cycle to sample `run`, 1 cycle for the transition).
- Strobes are combinational from the state and inputs. `mem_req` is purely state-decoded (Moore).
- The `instr_count` increment is visible the cycle after retirement.

## Configuration
- Macro: `CPU_SEQ_MEM_TIMEOUT_EN`.
- When defined:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle that `mem_ready` = 0.
  - If the counter reaches `TIMEOUT_CYCLES` − 1 with `mem_ready` still 0, the next state is FAULT.
  - `mem_ready` arriving in that same cycle wins.
- When undefined:
  - FETCH and MEM wait indefinitely.
  - `fault` is tied to 0.
  - The FAULT state is unreachable.

## Structure
- Package `cpu_seq_pkg` holds:
  - the state encoding constants and state typedef,
  - the `addr_sel` constants (`ADDR_PC`, `ADDR_DATA`).
- One sub-module, `cpu_seq_timeout`: the wait counter with a terminal-count output. It is instantiated only under the macro.

## Test plan
- Reset, then `run` pulse, then an ALU instruction (`dec_wr` = 1), zero-wait memory → `ir_load`/`pc_inc` in cycle 2, `reg_wr` in cycle 4, `instr_count` = 1.
- Load with `mem_ready` low for 3 cycles in MEM → `mem_req` high 4 cycles with `addr_sel` = 1 and `mem_we` = 0; `reg_wr` pulses once when ready arrives.
- `dec_ld` = `dec_st` = 1 → `mem_we` = 1 and `reg_wr` = 0 at retirement.
- Halt with `run` held high → remains in HALT. Drop then raise `run` → FETCH two cycles later. `instr_count` is unchanged by the halt.
- With the macro and `TIMEOUT_CYCLES` = 4, `mem_ready` stuck at 0 in FETCH → FAULT after 4 cycles; `fault` stays 1 until `reset`.
- `reset` asserted during MEM with `mem_req` = 1 → `mem_req` drops before the next clock; state = IDLE and `instr_count` = 0.
